// File: rtl/rc5_pkg.sv
// Shared constants, state encoding and rotate helpers for the RC5-16 engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc5_pkg;

  localparam int W         = 16;
  localparam int KEY_WORDS = 8;
  localparam int T_MAX     = 64;

  // Magic constants for w=16: P = Odd((e-2)*2^16), Q = Odd((phi-1)*2^16).
  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    MIX,
    CRYPT,
    DONE
  } algo_state_t;

  typedef enum logic {
    MODE_ENC,
    MODE_DEC
  } mode_t;

  // Rotate left by the low 4 bits; the doubled word makes the wrap implicit.
  function automatic logic [W-1:0] rotl16(input logic [W-1:0] x, input logic [3:0] n);
    logic [2*W-1:0] d;
    d = {x, x} << n;
    return d[2*W-1:W];
  endfunction

  // Rotate right by the low 4 bits.
  function automatic logic [W-1:0] rotr16(input logic [W-1:0] x, input logic [3:0] n);
    logic [2*W-1:0] d;
    d = {x, x} >> n;
    return d[W-1:0];
  endfunction

endpackage

// File: rtl/rc5_key_expand.sv
// Key schedule: owns S table and L words, runs INIT fill and MIX steps, exposes two S read ports.
// Latency: one S entry (INIT) or one mix step (MIX) per clock; read ports are combinational.
// Backpressure: none; sequenced entirely by the rc5_algo controller.
module rc5_key_expand
  import rc5_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [127:0]  i_key,
  input  logic          i_init_we,
  input  logic [5:0]    i_init_idx,
  input  logic          i_mix_en,
  input  logic [6:0]    i_t,
  input  logic [5:0]    i_rd_idx0,
  input  logic [5:0]    i_rd_idx1,
  output logic [W-1:0]  o_s_rd0,
  output logic [W-1:0]  o_s_rd1
);

  logic [W-1:0] r_s [T_MAX];
  logic [W-1:0] r_l [KEY_WORDS];
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [5:0]   r_i;
  logic [2:0]   r_j;

  logic [W-1:0] w_init_val;
  logic [W-1:0] w_sum_a;
  logic [W-1:0] w_a_new;
  logic [W-1:0] w_ab;
  logic [W-1:0] w_sum_b;
  logic [W-1:0] w_b_new;
  logic [6:0]   w_i_inc;

  // INIT builds the arithmetic progression from the previously written entry.
  assign w_init_val = (i_init_idx == 6'd0) ? P16 : (r_s[i_init_idx - 6'd1] + Q16);

  // One mix step: new A feeds straight into the B update of the same cycle.
  assign w_sum_a = r_s[r_i] + r_a + r_b;
  assign w_a_new = rotl16(w_sum_a, 4'd3);
  assign w_ab    = w_a_new + r_b;
  assign w_sum_b = r_l[r_j] + w_ab;
  assign w_b_new = rotl16(w_sum_b, w_ab[3:0]);
  assign w_i_inc = {1'b0, r_i} + 7'd1;

  assign o_s_rd0 = r_s[i_rd_idx0];
  assign o_s_rd1 = r_s[i_rd_idx1];

  // Table storage: contents are don't-care after reset, so no reset on the arrays.
  always_ff @(posedge clk) begin
    if (i_load) begin
      for (int k = 0; k < KEY_WORDS; k++) begin
        r_l[k] <= i_key[16*k +: 16];
      end
    end else if (i_mix_en) begin
      r_l[r_j] <= w_b_new;
    end
    if (i_init_we) begin
      r_s[i_init_idx] <= w_init_val;
    end else if (i_mix_en) begin
      r_s[r_i] <= w_a_new;
    end
  end

  // Mix accumulators and indices restart from zero on every new command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_i <= '0;
      r_j <= '0;
    end else if (i_load) begin
      r_a <= '0;
      r_b <= '0;
      r_i <= '0;
      r_j <= '0;
    end else if (i_mix_en) begin
      r_a <= w_a_new;
      r_b <= w_b_new;
      r_i <= (w_i_inc == i_t) ? 6'd0 : w_i_inc[5:0];
      r_j <= r_j + 3'd1;
    end
  end

endmodule

// File: rtl/rc5_algo.sv
// RC5-16/r/16 engine: latch command, expand key, run r rounds, hold {B,A} with done until commands drop.
// Latency: done rises t + 3*max(t,8) + r + 1 edges after the latching edge (t = 2r+2).
// Backpressure: none; command is a level, result held in DONE until encrypt and decrypt are both low.
module rc5_algo
  import rc5_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          encrypt,
  input  logic          decrypt,
  input  logic [4:0]    num_rounds,
  input  logic [127:0]  key,
  input  logic [31:0]   d_in,
  output logic [31:0]   d_out,
  output logic          done
);

  algo_state_t  algo_state;
  algo_state_t  w_state_nxt;

  mode_t        r_mode;
  logic [4:0]   r_rounds;
  logic [7:0]   r_cnt;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_done;
  logic [31:0]  r_dout;

  logic [6:0]   w_t;
  logic [7:0]   w_t_last;
  logic [7:0]   w_tm;
  logic [7:0]   w_mix_last;
  logic [4:0]   w_ridx;
  logic [W-1:0] w_s0;
  logic [W-1:0] w_s1;
  logic [W-1:0] w_a_nxt;
  logic [W-1:0] w_b_nxt;

  logic w_latch;
  logic w_init_we;
  logic w_mix_en;
  logic w_crypt_en;
  logic w_cnt_clr;
  logic w_finish;
  logic w_release;

  // Phase lengths derived from the latched round count.
  assign w_t        = {1'b0, r_rounds, 1'b0} + 7'd2;
  assign w_t_last   = {1'b0, w_t} - 8'd1;
  assign w_tm       = (w_t < 7'd8) ? 8'd8 : {1'b0, w_t};
  assign w_mix_last = w_tm + {w_tm[6:0], 1'b0} - 8'd1;

  // Encrypt walks rounds upward, decrypt downward; index 0 is always the whitening step.
  assign w_ridx = (r_mode == MODE_ENC) ? r_cnt[4:0] : (r_rounds - r_cnt[4:0]);

  rc5_key_expand u_kx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_latch),
    .i_key      (key),
    .i_init_we  (w_init_we),
    .i_init_idx (r_cnt[5:0]),
    .i_mix_en   (w_mix_en),
    .i_t        (w_t),
    .i_rd_idx0  ({w_ridx, 1'b0}),
    .i_rd_idx1  ({w_ridx, 1'b1}),
    .o_s_rd0    (w_s0),
    .o_s_rd1    (w_s1)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      algo_state <= IDLE;
    end else begin
      algo_state <= w_state_nxt;
    end
  end

  // Next-state and phase strobes; encrypt wins when both commands are high.
  always_comb begin
    w_state_nxt = algo_state;
    w_latch     = 1'b0;
    w_init_we   = 1'b0;
    w_mix_en    = 1'b0;
    w_crypt_en  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    case (algo_state)
      IDLE: begin
        if (encrypt || decrypt) begin
          w_state_nxt = INIT;
          w_latch     = 1'b1;
        end
      end
      INIT: begin
        w_init_we = 1'b1;
        if (r_cnt == w_t_last) begin
          w_state_nxt = MIX;
          w_cnt_clr   = 1'b1;
        end
      end
      MIX: begin
        w_mix_en = 1'b1;
        if (r_cnt == w_mix_last) begin
          w_state_nxt = CRYPT;
          w_cnt_clr   = 1'b1;
        end
      end
      CRYPT: begin
        w_crypt_en = 1'b1;
        if (r_cnt == {3'b000, r_rounds}) begin
          w_state_nxt = DONE;
          w_finish    = 1'b1;
        end
      end
      DONE: begin
        if (!encrypt && !decrypt) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One round (or the whitening step) per CRYPT cycle; the second half uses the fresh first half.
  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    if (r_mode == MODE_ENC) begin
      if (w_ridx == 5'd0) begin
        w_a_nxt = r_a + w_s0;
        w_b_nxt = r_b + w_s1;
      end else begin
        w_a_nxt = rotl16(r_a ^ r_b, r_b[3:0]) + w_s0;
        w_b_nxt = rotl16(r_b ^ w_a_nxt, w_a_nxt[3:0]) + w_s1;
      end
    end else begin
      if (w_ridx == 5'd0) begin
        w_b_nxt = r_b - w_s1;
        w_a_nxt = r_a - w_s0;
      end else begin
        w_b_nxt = rotr16(r_b - w_s1, r_a[3:0]) ^ r_a;
        w_a_nxt = rotr16(r_a - w_s0, w_b_nxt[3:0]) ^ w_b_nxt;
      end
    end
  end

  // Command latch, phase counter and the A/B working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= MODE_ENC;
      r_rounds <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_latch) begin
      r_mode   <= encrypt ? MODE_ENC : MODE_DEC;
      r_rounds <= num_rounds;
      r_a      <= d_in[15:0];
      r_b      <= d_in[31:16];
      r_cnt    <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_init_we || w_mix_en || w_crypt_en) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_crypt_en) begin
        r_a <= w_a_nxt;
        r_b <= w_b_nxt;
      end
    end
  end

  // Registered result: captured on the last CRYPT edge, done cleared when commands drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_dout <= '0;
    end else if (w_finish) begin
      r_done <= 1'b1;
      r_dout <= {w_b_nxt, w_a_nxt};
    end else if (w_release) begin
      r_done <= 1'b0;
    end
  end

  assign done  = r_done;
  assign d_out = r_dout;

endmodule

// File: tb/tb_rc5_algo.sv
// Self-checking bench for rc5_algo: vector table plus reset, priority and mid-run input-change sequences.
// Latency: checks exact done timing against t + 3*max(t,8) + r + 1.
// Backpressure: exercises hold-in-DONE and release-to-IDLE.
module tb_rc5_algo;
  import rc5_pkg::*;

  logic         clk;
  logic         rst;
  logic         encrypt;
  logic         decrypt;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic [31:0]  d_in;
  logic [31:0]  d_out;
  logic         done;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [127:0] key;
    logic [31:0]  din;
    logic [4:0]   r;
    bit           enc;
    logic [31:0]  want;
    string        name;
  } vec_t;

  vec_t vecs [10];

  rc5_algo dut (
    .clk        (clk),
    .rst        (rst),
    .encrypt    (encrypt),
    .decrypt    (decrypt),
    .num_rounds (num_rounds),
    .key        (key),
    .d_in       (d_in),
    .d_out      (d_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, want);
  endtask

  // Bit-serial rotates for the reference model.
  function automatic logic [15:0] m_rl(input logic [15:0] x, input int n);
    logic [15:0] y;
    y = x;
    for (int i = 0; i < (n % 16); i++) y = {y[14:0], y[15]};
    return y;
  endfunction

  function automatic logic [15:0] m_rr(input logic [15:0] x, input int n);
    logic [15:0] y;
    y = x;
    for (int i = 0; i < (n % 16); i++) y = {y[0], y[15:1]};
    return y;
  endfunction

  // Software RC5-16/r/16 reference.
  function automatic logic [31:0] model(input logic [127:0] k, input logic [31:0] d,
                                        input int r, input bit enc);
    logic [15:0] s [64];
    logic [15:0] l [8];
    logic [15:0] a, b, ab;
    int t, n, i, j;
    t = 2 * r + 2;
    s[0] = 16'hB7E1;
    for (int x = 1; x < t; x++) s[x] = s[x-1] + 16'h9E37;
    for (int x = 0; x < 8; x++) l[x] = k[16*x +: 16];
    a = '0; b = '0; i = 0; j = 0;
    n = 3 * ((t > 8) ? t : 8);
    for (int x = 0; x < n; x++) begin
      s[i] = m_rl(s[i] + a + b, 3);
      a = s[i];
      ab = a + b;
      l[j] = m_rl(l[j] + ab, int'(ab[3:0]));
      b = l[j];
      i = (i + 1) % t;
      j = (j + 1) % 8;
    end
    a = d[15:0];
    b = d[31:16];
    if (enc) begin
      a = a + s[0];
      b = b + s[1];
      for (int x = 1; x <= r; x++) begin
        a = m_rl(a ^ b, int'(b[3:0])) + s[2*x];
        b = m_rl(b ^ a, int'(a[3:0])) + s[2*x+1];
      end
    end else begin
      for (int x = r; x >= 1; x--) begin
        b = m_rr(b - s[2*x+1], int'(a[3:0])) ^ a;
        a = m_rr(a - s[2*x], int'(b[3:0])) ^ b;
      end
      b = b - s[1];
      a = a - s[0];
    end
    return {b, a};
  endfunction

  function automatic int calc_n(input int r);
    int t;
    t = 2 * r + 2;
    return t + 3 * ((t > 8) ? t : 8) + r + 1;
  endfunction

  // Call just before the latching edge; counts edges to done and tracks the state walk.
  task automatic wait_done(input int want_n, input logic [31:0] want_d, input string nm,
                           input int chg_at);
    int n;
    int stage;
    bit bad;
    algo_state_t ord [4];
    ord   = '{INIT, MIX, CRYPT, DONE};
    n     = 0;
    stage = 0;
    bad   = 1'b0;
    @(posedge clk); #1;
    if (dut.algo_state != INIT) bad = 1'b1;
    while (!done && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (n == chg_at) begin
        key        = ~key;
        d_in       = ~d_in;
        num_rounds = num_rounds + 5'd7;
      end
      if (dut.algo_state != ord[stage]) begin
        if (stage < 3 && dut.algo_state == ord[stage+1]) stage++;
        else bad = 1'b1;
      end
    end
    chk($sformatf("%s_latency", nm), n, want_n);
    chk($sformatf("%s_dout", nm), d_out, want_d);
    chk($sformatf("%s_stateseq", nm), {31'd0, (stage == 3 && !bad)}, 32'd1);
  endtask

  task automatic run_op(input logic [127:0] k, input logic [31:0] d, input logic [4:0] r,
                        input bit en, input bit de, input logic [31:0] want,
                        input string nm, input int chg_at);
    @(negedge clk);
    chk($sformatf("%s_idle_before", nm), 32'(dut.algo_state), 32'(IDLE));
    key        = k;
    d_in       = d;
    num_rounds = r;
    encrypt    = en;
    decrypt    = de;
    wait_done(calc_n(int'(r)), want, nm, chg_at);
    @(posedge clk); #1;
    chk($sformatf("%s_hold_done", nm), {31'd0, done}, 32'd1);
    chk($sformatf("%s_hold_dout", nm), d_out, want);
    @(negedge clk);
    encrypt = 1'b0;
    decrypt = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s_rel_done", nm), {31'd0, done}, 32'd0);
    chk($sformatf("%s_rel_state", nm), 32'(dut.algo_state), 32'(IDLE));
    chk($sformatf("%s_rel_dout", nm), d_out, want);
  endtask

  initial begin
    logic [127:0] k1;
    logic [31:0]  d1;
    logic [31:0]  ct;
    logic [4:0]   rl [4];

    rst        = 1'b0;
    encrypt    = 1'b0;
    decrypt    = 1'b0;
    num_rounds = '0;
    key        = '0;
    d_in       = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dout", d_out, 32'd0);
    chk("reset_state", 32'(dut.algo_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    k1 = 128'h000102030405060708090A0B0C0D0E0F;
    d1 = 32'h12345678;
    rl = '{5'd0, 5'd1, 5'd12, 5'd31};
    vecs[0] = '{128'h0, 32'h0, 5'd16, 1'b1, model(128'h0, 32'h0, 16, 1'b1), "key0_r16_enc"};
    for (int q = 0; q < 4; q++) begin
      ct = model(k1, d1, int'(rl[q]), 1'b1);
      vecs[1+2*q] = '{k1, d1, rl[q], 1'b1, ct, $sformatf("enc_r%0d", rl[q])};
      vecs[2+2*q] = '{k1, ct, rl[q], 1'b0, 32'h12345678, $sformatf("roundtrip_dec_r%0d", rl[q])};
    end
    vecs[9] = '{128'h0, 32'h0, 5'd0, 1'b1, model(128'h0, 32'h0, 0, 1'b1), "key0_r0_whiten"};

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].key, vecs[v].din, vecs[v].r, vecs[v].enc, !vecs[v].enc,
             vecs[v].want, vecs[v].name, -1);
    end

    // Both commands high: encrypt must win.
    run_op(k1, d1, 5'd12, 1'b1, 1'b1, model(k1, d1, 12, 1'b1), "both_high", -1);

    // Inputs scrambled well inside MIX (t=26, MIX spans edges 27..104) must not matter.
    run_op(k1, 32'hCAFEBABE, 5'd12, 1'b1, 1'b0, model(k1, 32'hCAFEBABE, 12, 1'b1),
           "mix_change", 36);

    // Reset during CRYPT clears outputs without an edge, then a held encrypt restarts cleanly.
    @(negedge clk);
    key        = k1;
    d_in       = 32'h0BADF00D;
    num_rounds = 5'd31;
    encrypt    = 1'b1;
    decrypt    = 1'b0;
    @(posedge clk);
    repeat (calc_n(31) - 10) @(posedge clk);
    #3;
    chk("rst_pre_state", 32'(dut.algo_state), 32'(CRYPT));
    rst = 1'b1;
    #1;
    chk("rst_async_done", {31'd0, done}, 32'd0);
    chk("rst_async_dout", d_out, 32'd0);
    chk("rst_async_state", 32'(dut.algo_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    wait_done(calc_n(31), model(k1, 32'h0BADF00D, 31, 1'b1), "rst_rerun", -1);
    @(negedge clk);
    encrypt = 1'b0;
    @(posedge clk); #1;
    chk("rst_rerun_rel_done", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rc5_algo.md
# rc5_algo

RC5-16/r/16 block-cipher engine: 32-bit block, 16-bit words, 128-bit key, 0–31 rounds selected at run time. On an encrypt or decrypt command it expands the key into the S table, runs the rounds and presents the 32-bit result with a `done` flag. It is the compute core of the RC5 accelerator and sits under the host or register interface, which drives the command, key and data inputs.

## Interface
- No parameters. Constants live in the package (see Structure).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `encrypt` input 1: level command to encrypt `d_in`.
- `decrypt` input 1: level command to decrypt `d_in`.
- `num_rounds` input 5: round count r, not zero-indexed (16 means 16 rounds). Range 0–31.
- `key` input 128: secret key. Byte k is `key[8k+7:8k]`. Word L[k] is `key[16k+15:16k]`, for k = 0..7.
- `d_in` input 32: input block. A = `d_in[15:0]`, B = `d_in[31:16]`.
- `d_out` output 32: result block `{B,A}`. Reset value 0.
- `done` output 1: result valid. Reset value 0.

## Operation
- Table size t = 2r+2 (2–64 entries of 16 bits). Key-word count c = 8.
- Constants: P = 16'hB7E1, Q = 16'h9E37.
- All arithmetic is mod 2^16. Rotate amounts use the low 4 bits of the operand.
- State register `algo_state`, observable hierarchically, with states IDLE, INIT, MIX, CRYPT, DONE.
- IDLE:
  - If `encrypt` is high, latch key, d_in, num_rounds and mode=ENC.
  - Else if `decrypt` is high, latch the same with mode=DEC.
  - Encrypt has priority when both are high.
  - On a latch, go to INIT.
- INIT: one entry per cycle. S[0]=P, S[i]=S[i-1]+Q, for i < t. Takes t cycles, then go to MIX.
- MIX: 3·max(t,8) cycles, one step per cycle. i, j, A, B all start at 0.
  - A = S[i] = (S[i]+A+B) <<< 3
  - B = L[j] = (L[j]+A+B) <<< (A+B)
  - i = (i+1) mod t, j = (j+1) mod 8
  - Then go to CRYPT.
- CRYPT with ENC: r+1 cycles.
  - Cycle 0: A += S[0], B += S[1].
  - Cycle i (1..r): A = ((A^B) <<< B) + S[2i], then B = ((B^A) <<< A) + S[2i+1], using the new A.
- CRYPT with DEC: r+1 cycles.
  - Cycles for i = r down to 1: B = ((B−S[2i+1]) >>> A) ^ A, then A = ((A−S[2i]) >>> B) ^ B, using the new B.
  - Final cycle: B −= S[1], A −= S[0].
- r=0: ENC or DEC performs only the whitening step.
- DONE:
  - `d_out` = {B,A} and `done` = 1, both held stable.
  - Leave to IDLE once `encrypt` and `decrypt` are both low. `done` then falls and `d_out` holds its last value.
- Input changes after the latching edge are ignored until the next IDLE.

## Timing
- Let N = t + 3·max(t,8) + r + 1, counted in edges after the latching edge.
  - `done` rises N edges after the latching edge.
  - Example: r=16 gives N = 34 + 102 + 17 = 153.
- `done` and `d_out` are registered outputs and update together.
- Minimum turnaround is 1 cycle in IDLE between commands.
- Asserting `rst` at any time, including mid-INIT, MIX or CRYPT:
  - immediately forces IDLE with `done`=0 and `d_out`=0;
  - aborts the operation;
  - leaves S/L contents don't-care.
- Deasserting `rst` with a command level already high starts a new operation on the first following edge.

## Structure
- Package `rc5_pkg` holds:
  - W=16, P16, Q16, KEY_WORDS=8, T_MAX=64;
  - the `algo_state_t` enum;
  - `rotl16`/`rotr16` functions.
- One natural sub-module: `rc5_key_expand`. It owns the S table (64×16 registers) and L, performs INIT and MIX, and exposes S read ports to the round datapath.

## Test plan
- key=0, r=16, d_in=0, encrypt held high:
  - `done` rises exactly 153 edges after the latching edge;
  - `d_out` matches the software RC5-16/16/16 model;
  - `algo_state` passes IDLE→INIT→MIX→CRYPT→DONE.
- key=128'h000102…0F, d_in=32'h12345678, r ∈ {0,1,12,31}: encrypt, then decrypt the result → the original 32'h12345678 returns.
  - Each `d_out` matches the model.
- encrypt and decrypt both high from IDLE → encrypt performed.
  - Drop both → IDLE next edge, `done`=0.
- Change key/d_in/num_rounds mid-MIX → result unchanged versus stable inputs.
- Assert `rst` mid-CRYPT → `done`=0 and `d_out`=0 immediately, without a clock edge.
  - Release `rst` with encrypt still high → full new run with correct result.
- r=0, key=0, d_in=0: result equals {S[1],S[0]} after MIX, checked against the model.
